gray_step_monitor: RTL and testbench
====================================

# gray_step_monitor

Downstream consumer of the Gray-code counter output. It registers the incoming Gray code and converts it to binary. It checks every sample-to-sample transition against the previous sample: +1 step, −1 step, hold, or illegal jump. Illegal jumps are counted and flagged, and a lock state machine reports whether the upstream counter is currently trusted; debug and status logic read this result.

## Interface
- WIDTH, 8: Gray/binary code width.
- ERR_CNT_W, 8: width of saturating error counter.
- LOCK_CNT, 2: consecutive good steps needed to re-lock after an error (≥1).

Ports:
- clk  in  1  single clock; all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample enable; gray_in captured only when high.
- gray_in  in  WIDTH  Gray code from upstream counter.
- clr  in  1  synchronous clear of err_count and err_sticky.
- bin_out  out  WIDTH  binary value of last evaluated sample.
- bin_valid  out  1  high once bin_out holds a converted sample; stays high until rst.
- step_up  out  1  one-cycle pulse: binary +1 (mod 2^WIDTH).
- step_dn  out  1  one-cycle pulse: binary −1 (mod 2^WIDTH).
- step_err  out  1  one-cycle pulse: change that is neither +1 nor −1.
- err_sticky  out  1  set on any step_err; cleared by clr or rst.
- err_count  out  ERR_CNT_W  saturating count of step_err pulses.
- locked  out  1  high in LOCK state.

## Operation
- Stage 1: g1 <= gray_in and v1 <= 1 when en. When en is low, g1 holds and v1 <= 0.
- Stage 2 acts only when v1=1. It sets bin_out <= g2b(g1) and prev_bin <= g2b(g1), and evaluates g2b(g1) against prev_bin.
- Classification uses modular WIDTH-bit arithmetic:
  - equal: hold, no flag.
  - prev+1: step_up.
  - prev−1: step_dn.
  - any other value: step_err.
  - A single-bit Gray change can still be illegal, e.g. 0x01→0x05.
- FSM states:
  - ACQ (reset state): first v1 cycle loads prev_bin and sets bin_valid; no classification is made; go to LOCK.
  - LOCK: step_err → go to RESYNC and clear good_cnt.
  - RESYNC: each step_up or step_dn increments good_cnt; when good_cnt reaches LOCK_CNT, go to LOCK. A step_err clears good_cnt and stays in RESYNC. A hold changes nothing.
- Error accounting:
  - Every step_err, in any state, sets err_sticky and increments err_count, saturating at all-ones.
  - clr zeroes both; if a step_err occurs in the same cycle, the error wins: err_count=1, err_sticky=1.
- At most one of step_up, step_dn, step_err is high in any cycle.

## Timing
- Latency: gray_in sampled at edge N → bin_out and step flags valid after edge N+1.
- Flag pulses last exactly one cycle. All step flags are low in any cycle whose stage-2 input had v1=0.
- rst asserts asynchronously at any time. Reset values:
  - bin_out, err_count, good_cnt: 0.
  - bin_valid, step_up, step_dn, step_err, err_sticky, locked: 0.
  - FSM state: ACQ; g1: 0; v1: 0.
- Reset mid-stream discards all history. The first sample after release produces no step flag.
- Gaps in en do not break continuity: comparison is always against the last evaluated sample.
- Wrap-around: (2^WIDTH−1)→0 is step_up and 0→(2^WIDTH−1) is step_dn; neither is an error.

## Structure
- Package gray_pkg holds:
  - the state enum {ACQ, LOCK, RESYNC};
  - the g2b conversion function, parameterised by width.
- Sub-module gray_to_bin: purely combinational prefix-XOR, instantiated once at stage 2.
- The FSM, counters and flags live in the top module.

## Test plan
1. Reset, en=1, gray_in 0x00,0x01,0x03,0x02,0x06 → bin_out 0,1,2,3,4 two edges after each sample; step_up pulses from the second sample on; locked=1 after the first evaluation; err_count=0.
2. Wrap: gray_in 0x80 (bin 255) then 0x00 → step_up, bin_out 0. Then 0x00→0x80 → step_dn, bin_out 255, no error.
3. Hold and gaps: 0x03 for three cycles, then en=0 for 4 cycles, then 0x02 → no flags during hold or gap, then one step_up with bin_out 3.
4. Illegal jump while locked: 0x02 (bin 3)→0x07 (bin 5) → step_err pulse, err_sticky=1, err_count=1, locked=0. Then 0x06, 0x0A:
   - After 0x06 (bin 4), bin 5→4 is step_dn, good_cnt=1.
   - After 0x0A (bin 12), the jump is a second step_err, err_count=2, good_cnt cleared.
   - Two further legal steps → locked=1 on the second.
5. clr in the same cycle as a step_err with err_count=5 → err_count=1, err_sticky=1. Force 300 errors with ERR_CNT_W=8 → err_count saturates at 255.
6. Assert rst asynchronously mid-count (between clock edges) → all outputs 0 immediately. After release, sample 0x03 → bin_valid=1, bin_out 2, no step flag; locked=1 on the following edge.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code step monitor.
//   state_t : lock state machine encoding
//   g2b     : Gray-to-binary conversion for any width up to G2B_MAX_W
package gray_pkg;

  localparam int unsigned G2B_MAX_W = 64;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    LOCK   = 2'd1,
    RESYNC = 2'd2
  } state_t;

  // Prefix XOR from the MSB down. Narrower codes are zero-extended by the
  // caller; leading zeros do not change the low bits of the result, so one
  // function serves every width.
  function automatic logic [G2B_MAX_W-1:0] g2b(input logic [G2B_MAX_W-1:0] g);
    logic [G2B_MAX_W-1:0] b;
    b = '0;
    b[G2B_MAX_W-1] = g[G2B_MAX_W-1];
    for (int i = int'(G2B_MAX_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter.
//   gray  : Gray-coded input, WIDTH bits
//   bin_c : binary equivalent, WIDTH bits (combinational)
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin_c
);

  assign bin_c = WIDTH'(g2b(G2B_MAX_W'(gray)));

endmodule

// File: rtl/gray_step_monitor.sv
// Monitors a Gray-code counter stream: registers each sample, converts it to
// binary and classifies every transition as +1, -1, hold or illegal jump.
// Illegal jumps are counted/flagged and a lock FSM tracks upstream trust.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : sample enable for gray_in
//   gray_in    : Gray code from the upstream counter
//   clr        : synchronous clear of err_count / err_sticky
//   bin_out    : binary value of the last evaluated sample
//   bin_valid  : bin_out holds a converted sample
//   step_up/dn : one-cycle pulses for +1 / -1 steps (modular)
//   step_err   : one-cycle pulse for any other change
//   err_sticky : set by step_err, cleared by clr
//   err_count  : saturating count of step_err pulses
//   locked     : FSM is in LOCK
module gray_step_monitor
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_CNT_W = 8,
  parameter int unsigned LOCK_CNT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clr,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 step_up,
  output logic                 step_dn,
  output logic                 step_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 locked
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

  state_t               state, state_d;
  logic [WIDTH-1:0]     g1;
  logic                 v1;
  logic [WIDTH-1:0]     bin_c;
  logic [GOOD_W-1:0]    good_cnt, good_cnt_d;
  logic                 up_c, dn_c, err_c;
  logic [ERR_CNT_W-1:0] err_count_d;
  logic                 err_sticky_d;

  // Stage 1: capture sample; g1 holds across enable gaps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g1 <= '0;
      v1 <= 1'b0;
    end else begin
      if (en) g1 <= gray_in;
      v1 <= en;
    end
  end

  gray_to_bin #(.WIDTH(WIDTH)) u_g2b (
    .gray  (g1),
    .bin_c (bin_c)
  );

  // Classification, next state, lock-count and error accounting.
  // bin_out doubles as the previous evaluated sample.
  always_comb begin
    state_d      = state;
    good_cnt_d   = good_cnt;
    up_c         = 1'b0;
    dn_c         = 1'b0;
    err_c        = 1'b0;
    err_count_d  = err_count;
    err_sticky_d = err_sticky;

    if (v1 && (state != ACQ)) begin
      if (bin_c == WIDTH'(bin_out + WIDTH'(1))) begin
        up_c = 1'b1;
      end else if (bin_c == WIDTH'(bin_out - WIDTH'(1))) begin
        dn_c = 1'b1;
      end else if (bin_c != bin_out) begin
        err_c = 1'b1;
      end
    end

    case (state)
      ACQ: begin
        if (v1) state_d = LOCK;
      end
      LOCK: begin
        if (err_c) begin
          state_d    = RESYNC;
          good_cnt_d = '0;
        end
      end
      RESYNC: begin
        if (err_c) begin
          good_cnt_d = '0;
        end else if (up_c || dn_c) begin
          // Incremented count reaching LOCK_CNT re-locks
          if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
            state_d    = LOCK;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = GOOD_W'(good_cnt + GOOD_W'(1));
          end
        end
      end
      default: begin
        state_d    = ACQ;
        good_cnt_d = '0;
      end
    endcase

    // An error in the same cycle as clr still counts as the first error
    if (err_c) begin
      err_sticky_d = 1'b1;
      if (clr) begin
        err_count_d = ERR_CNT_W'(1);
      end else if (err_count != '1) begin
        err_count_d = ERR_CNT_W'(err_count + ERR_CNT_W'(1));
      end
    end else if (clr) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACQ;
    else     state <= state_d;
  end

  // Stage 2 registers and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      step_up    <= 1'b0;
      step_dn    <= 1'b0;
      step_err   <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      good_cnt   <= '0;
      locked     <= 1'b0;
    end else begin
      if (v1) begin
        bin_out   <= bin_c;
        bin_valid <= 1'b1;
      end
      step_up    <= up_c;
      step_dn    <= dn_c;
      step_err   <= err_c;
      err_sticky <= err_sticky_d;
      err_count  <= err_count_d;
      good_cnt   <= good_cnt_d;
      locked     <= (state_d == LOCK);
    end
  end

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed bench for gray_step_monitor: vector table plus hand sequences for
// clear/error collision, counter saturation and asynchronous reset.
module tb_gray_step_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] gray_in = 8'h00;
  logic       clr = 1'b0;
  logic [7:0] bin_out;
  logic       bin_valid, step_up, step_dn, step_err, err_sticky, locked;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  gray_step_monitor #(.WIDTH(8), .ERR_CNT_W(8), .LOCK_CNT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .gray_in    (gray_in),
    .clr        (clr),
    .bin_out    (bin_out),
    .bin_valid  (bin_valid),
    .step_up    (step_up),
    .step_dn    (step_dn),
    .step_err   (step_err),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // Each row: optional reset, inputs applied before an edge, and the outputs
  // expected just after that edge (which reflect the previous row's sample).
  typedef struct {
    logic       do_rst;
    logic       en;
    logic [7:0] g;
    logic       clr;
    logic [7:0] bin;
    logic       valid;
    logic       up;
    logic       dn;
    logic       err;
    logic       sticky;
    logic [7:0] cnt;
    logic       lck;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic [7:0] g,
                              input logic c, input logic [7:0] b, input logic v,
                              input logic u, input logic d, input logic er,
                              input logic s, input logic [7:0] n, input logic l);
    vec_t x;
    x.do_rst = r; x.en = e; x.g = g; x.clr = c; x.bin = b; x.valid = v;
    x.up = u; x.dn = d; x.err = er; x.sticky = s; x.cnt = n; x.lck = l;
    return x;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic [7:0] b,
                           input logic v, input logic u, input logic d,
                           input logic er, input logic s, input logic [7:0] n,
                           input logic l);
    check({tag, ".bin_out"},    idx, 32'(bin_out),    32'(b));
    check({tag, ".bin_valid"},  idx, 32'(bin_valid),  32'(v));
    check({tag, ".step_up"},    idx, 32'(step_up),    32'(u));
    check({tag, ".step_dn"},    idx, 32'(step_dn),    32'(d));
    check({tag, ".step_err"},   idx, 32'(step_err),   32'(er));
    check({tag, ".err_sticky"}, idx, 32'(err_sticky), 32'(s));
    check({tag, ".err_count"},  idx, 32'(err_count),  32'(n));
    check({tag, ".locked"},     idx, 32'(locked),     32'(l));
  endtask

  task automatic drive(input logic e, input logic [7:0] g, input logic c);
    en = e; gray_in = g; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; gray_in = 8'h00; clr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Count up 0..4, hold, enable gap, then illegal jumps and re-lock
    //                 rst en g     clr bin    v  up dn er st cnt  lk
    vecs.push_back(mk(1, 1, 8'h00, 0, 8'd0,   0, 0, 0, 0, 0, 8'd0, 0));
    vecs.push_back(mk(0, 1, 8'h01, 0, 8'd0,   1, 0, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 1, 8'h03, 0, 8'd1,   1, 1, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 1, 8'h02, 0, 8'd2,   1, 1, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 1, 8'h06, 0, 8'd3,   1, 1, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 1, 8'h06, 0, 8'd4,   1, 1, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 1, 8'h06, 0, 8'd4,   1, 0, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 0, 8'hFF, 0, 8'd4,   1, 0, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 0, 8'hFF, 0, 8'd4,   1, 0, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 0, 8'hFF, 0, 8'd4,   1, 0, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 0, 8'hFF, 0, 8'd4,   1, 0, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 1, 8'h07, 0, 8'd4,   1, 0, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 1, 8'h0C, 0, 8'd5,   1, 1, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 1, 8'h0D, 0, 8'd8,   1, 0, 0, 1, 1, 8'd1, 0));
    vecs.push_back(mk(0, 1, 8'h05, 0, 8'd9,   1, 1, 0, 0, 1, 8'd1, 0));
    vecs.push_back(mk(0, 1, 8'h04, 0, 8'd6,   1, 0, 0, 1, 1, 8'd2, 0));
    vecs.push_back(mk(0, 1, 8'h05, 0, 8'd7,   1, 1, 0, 0, 1, 8'd2, 0));
    vecs.push_back(mk(0, 1, 8'h05, 0, 8'd6,   1, 0, 1, 0, 1, 8'd2, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'd6,   1, 0, 0, 0, 1, 8'd2, 1));
    // Wrap-around both directions after a fresh reset
    vecs.push_back(mk(1, 1, 8'h80, 0, 8'd0,   0, 0, 0, 0, 0, 8'd0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 0, 8'd255, 1, 0, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 1, 8'h80, 0, 8'd0,   1, 1, 0, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 1, 8'h80, 0, 8'd255, 1, 0, 1, 0, 0, 8'd0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'd255, 1, 0, 0, 0, 0, 8'd0, 1));

    #2;
    check_all("reset", 0, 8'd0, 0, 0, 0, 0, 0, 8'd0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      drive(vecs[i].en, vecs[i].g, vecs[i].clr);
      check_all("vec", i, vecs[i].bin, vecs[i].valid, vecs[i].up, vecs[i].dn,
                vecs[i].err, vecs[i].sticky, vecs[i].cnt, vecs[i].lck);
    end

    // Five errors (bin 0 <-> 2), then clr collides with a sixth error
    do_reset();
    drive(1, 8'h00, 0);
    drive(1, 8'h03, 0);
    drive(1, 8'h00, 0);
    drive(1, 8'h03, 0);
    drive(1, 8'h00, 0);
    drive(1, 8'h03, 0);
    drive(1, 8'h00, 0);
    check("clr.pre_count", 0, 32'(err_count), 32'd5);
    drive(1, 8'h00, 1);
    check("clr.collide_count",  0, 32'(err_count),  32'd1);
    check("clr.collide_sticky", 0, 32'(err_sticky), 32'd1);
    check("clr.collide_err",    0, 32'(step_err),   32'd1);
    drive(1, 8'h00, 1);
    check("clr.plain_count",  0, 32'(err_count),  32'd0);
    check("clr.plain_sticky", 0, 32'(err_sticky), 32'd0);

    // 300 alternating illegal jumps must saturate the counter
    for (int k = 0; k < 300; k++) begin
      drive(1, (k % 2 == 0) ? 8'h03 : 8'h00, 0);
      check("sat.onehot", k, 32'(step_up) + 32'(step_dn) + 32'(step_err), 32'(step_err));
    end
    check("sat.count",  0, 32'(err_count),  32'd255);
    check("sat.sticky", 0, 32'(err_sticky), 32'd1);
    check("sat.locked", 0, 32'(locked),     32'd0);

    // Asynchronous reset between edges clears everything immediately
    #2;
    rst = 1'b1;
    #1;
    check_all("async", 0, 8'd0, 0, 0, 0, 0, 0, 8'd0, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    en = 1'b0;
    @(negedge clk);
    drive(1, 8'h03, 0);
    check_all("post_rst", 0, 8'd0, 0, 0, 0, 0, 0, 8'd0, 0);
    drive(1, 8'h03, 0);
    check_all("post_rst", 1, 8'd2, 1, 0, 0, 0, 0, 8'd0, 1);
    drive(1, 8'h02, 0);
    check_all("post_rst", 2, 8'd2, 1, 0, 0, 0, 0, 8'd0, 1);
    drive(0, 8'h00, 0);
    check_all("post_rst", 3, 8'd3, 1, 1, 0, 0, 0, 8'd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
